// File: rtl/instr_enc.sv
// Purpose: packs RV32 fields and a decode-style immediate into an instruction word, with range checks.
// Latency: one cycle from request accept to registered output word; a two-word LI adds one more word.
// Backpressure: holds its word until out_ready; in_ready follows out_ready combinationally while FULL.
// Optional feature: define INSTR_ENC_LI_EN to expand the LI pseudo-instruction into LUI+ADDI.
module instr_enc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    localparam logic [31:0] ILLEGAL_WORD = 32'h0000_0000;
    localparam logic [2:0]  FMT_R  = 3'd0;
    localparam logic [2:0]  FMT_I  = 3'd1;
    localparam logic [2:0]  FMT_S  = 3'd2;
    localparam logic [2:0]  FMT_B  = 3'd3;
    localparam logic [2:0]  FMT_U  = 3'd4;
    localparam logic [2:0]  FMT_J  = 3'd5;
`ifdef INSTR_ENC_LI_EN
    localparam logic [2:0]  FMT_LI = 3'd6;
    localparam logic [6:0]  OP_LUI = 7'h37;
    localparam logic [6:0]  OP_IMM = 7'h13;

    typedef enum logic [1:0] {EMPTY, FULL, LI_HI} state_t;
`else
    typedef enum logic [1:0] {EMPTY, FULL} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic        accept;

    logic [31:0] enc_word;
    logic        enc_err;
    logic        imm12_ok, b_ok, j_ok, u_ok;
`ifdef INSTR_ENC_LI_EN
    logic        enc_two;
    logic [31:0] enc_addi;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic [31:0] addi_q, addi_d;
`endif

    // Immediate range checks: upper bits must be a pure sign extension of the encodable field.
    assign imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign b_ok     = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign j_ok     = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign u_ok     = ~(|in_imm[11:0]);

    // Field packing for the request currently on the input; errors force the illegal word.
    always_comb begin
        enc_word = ILLEGAL_WORD;
        enc_err  = 1'b0;
`ifdef INSTR_ENC_LI_EN
        enc_two  = 1'b0;
        enc_addi = ILLEGAL_WORD;
        // ADDI sign-extends lo, so the upper half is rounded up when lo's top bit is set.
        li_hi    = in_imm[31:12] + {19'd0, in_imm[11]};
        li_lo    = in_imm[11:0];
`endif
        case (in_fmt)
            FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: begin
                if (imm12_ok) enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                else          enc_err  = 1'b1;
            end
            FMT_S: begin
                if (imm12_ok) enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                else          enc_err  = 1'b1;
            end
            FMT_B: begin
                if (b_ok) enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                      in_imm[4:1], in_imm[11], in_opcode};
                else      enc_err  = 1'b1;
            end
            FMT_U: begin
                if (u_ok) enc_word = {in_imm[31:12], in_rd, in_opcode};
                else      enc_err  = 1'b1;
            end
            FMT_J: begin
                if (j_ok) enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                else      enc_err  = 1'b1;
            end
`ifdef INSTR_ENC_LI_EN
            FMT_LI: begin
                if (li_hi == 20'd0) begin
                    enc_word = {li_lo, 5'd0, 3'b000, in_rd, OP_IMM};
                end else if (li_lo == 12'd0) begin
                    enc_word = {li_hi, in_rd, OP_LUI};
                end else begin
                    enc_word = {li_hi, in_rd, OP_LUI};
                    enc_addi = {li_lo, in_rd, 3'b000, in_rd, OP_IMM};
                    enc_two  = 1'b1;
                end
            end
`endif
            default: enc_err = 1'b1;
        endcase
    end

    // Output-slot FSM: accept into EMPTY/FULL, drain LI_HI's staged ADDI before taking new work.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        err_d    = err_q;
        last_d   = last_q;
`ifdef INSTR_ENC_LI_EN
        addi_d   = addi_q;
`endif
        in_ready = (state_q == EMPTY) || ((state_q == FULL) && out_ready);
        accept   = in_valid && in_ready;
        if (accept) begin
            instr_d = enc_word;
            err_d   = enc_err;
            state_d = FULL;
            last_d  = 1'b1;
`ifdef INSTR_ENC_LI_EN
            if (enc_two) begin
                state_d = LI_HI;
                last_d  = 1'b0;
                addi_d  = enc_addi;
            end
`endif
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
`ifdef INSTR_ENC_LI_EN
        else if ((state_q == LI_HI) && out_ready) begin
            state_d = FULL;
            instr_d = addi_q;
            err_d   = 1'b0;
            last_d  = 1'b1;
        end
`endif
    end

    // State and output registers; reset also drops any staged ADDI.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            instr_q <= ILLEGAL_WORD;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
`ifdef INSTR_ENC_LI_EN
            addi_q  <= ILLEGAL_WORD;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            last_q  <= last_d;
`ifdef INSTR_ENC_LI_EN
            addi_q  <= addi_d;
`endif
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_last  = last_q;

endmodule
